program_loader: RTL and testbench

//  Boot-time instruction loader directly upstream of CPU. Receives a byte stream
//  (length header + program words) and writes it into InstructionMemory through a

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_word_assembler.sv | 35 +++
 rtl/program_loader.sv | 147 ++++++++++++++
 tb/tb_program_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader.
package program_loader_pkg;

  // Loader FSM states: two header bytes, payload, then terminal states.
  typedef enum logic [2:0] {
    LOADER_LEN_HI = 3'd0,
    LOADER_LEN_LO = 3'd1,
    LOADER_DATA   = 3'd2,
    LOADER_DONE   = 3'd3,
    LOADER_ERR    = 3'd4
  } loader_state_e;

  // Width of the big-endian word-count header.
  localparam int LEN_W = 16;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input loader_state_e s);
    return (s == LOADER_LEN_HI) || (s == LOADER_LEN_LO) || (s == LOADER_DATA);
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs four stream bytes (big-endian) into one 32-bit instruction word.
module program_loader_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // Byte position within the current word; clear drops any partial word.
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_cnt <= 2'd0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  // First three bytes of the word, oldest in the top byte.
  always_ff @(posedge clock) begin
    if (i_byte_en) begin
      r_shift <= {r_shift[15:0], i_byte};
    end
  end

  // The fourth byte completes the word combinationally; the top registers it.
  assign o_word_valid = i_byte_en & (r_cnt == 2'd3);
  assign o_word       = {r_shift, i_byte};

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes instruction memory,
// and releases the CPU (cpu_run) once the whole program has been written.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_req,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   loaded_count
);

  localparam logic [LEN_W:0] DEPTH_V = (LEN_W+1)'(2**ADDR_WIDTH);

  loader_state_e           r_state, w_state_nxt;
  logic [7:0]              r_len_hi;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_word_cnt;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [31:0]             r_mem_wdata;
  logic                    r_cpu_run;
  logic                    r_load_error;
  logic [ADDR_WIDTH:0]     r_loaded_count;

  logic                    w_accept;
  logic                    w_byte_en;
  logic                    w_word_valid;
  logic                    w_take_word;
  logic [31:0]             w_word;
  logic [LEN_W-1:0]        w_hdr_len;

  assign byte_ready  = ~load_req & accepts_bytes(r_state);
  assign w_accept    = byte_valid & byte_ready;
  assign w_byte_en   = w_accept & (r_state == LOADER_DATA);
  assign w_hdr_len   = {r_len_hi, byte_data};
  // Ignore anything that completes after the last expected word.
  assign w_take_word = w_word_valid & (r_word_cnt != r_len);

  program_loader_word_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (load_req),
    .i_byte_en    (w_byte_en),
    .i_byte       (byte_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= LOADER_LEN_HI;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: load_req restarts from any state; DATA ends on the final write.
  always_comb begin
    w_state_nxt = r_state;
    if (load_req) begin
      w_state_nxt = LOADER_LEN_HI;
    end else begin
      unique case (r_state)
        LOADER_LEN_HI: if (w_accept) w_state_nxt = LOADER_LEN_LO;
        LOADER_LEN_LO: begin
          if (w_accept) begin
            if (w_hdr_len == '0)                    w_state_nxt = LOADER_DONE;
            else if ({1'b0, w_hdr_len} > DEPTH_V)   w_state_nxt = LOADER_ERR;
            else                                    w_state_nxt = LOADER_DATA;
          end
        end
        LOADER_DATA:   if (r_mem_we && (r_word_cnt == r_len)) w_state_nxt = LOADER_DONE;
        default:       ;
      endcase
    end
  end

  // Header capture: high byte first, full count on the second byte.
  always_ff @(posedge clock) begin
    if (w_accept && (r_state == LOADER_LEN_HI)) r_len_hi <= byte_data;
    if (w_accept && (r_state == LOADER_LEN_LO)) r_len    <= w_hdr_len;
  end

  // Count of words assembled in this load; also the next word index.
  always_ff @(posedge clock) begin
    if (reset || load_req) begin
      r_word_cnt <= '0;
    end else if (w_take_word) begin
      r_word_cnt <= r_word_cnt + 1'b1;
    end
  end

  // Memory write port, registered one cycle after the word's last byte.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_WIDTH'(BASE_ADDR);
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_take_word;
      if (w_take_word) begin
        r_mem_addr  <= ADDR_WIDTH'(BASE_ADDR) + r_word_cnt[ADDR_WIDTH-1:0];
        r_mem_wdata <= w_word;
      end
    end
  end

  // Words actually written in this load.
  always_ff @(posedge clock) begin
    if (reset || load_req) begin
      r_loaded_count <= '0;
    end else if (r_mem_we) begin
      r_loaded_count <= r_loaded_count + 1'b1;
    end
  end

  // Status flags follow the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cpu_run    <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_cpu_run    <= (w_state_nxt == LOADER_DONE);
      r_load_error <= (w_state_nxt == LOADER_ERR);
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_run      = r_cpu_run;
  assign load_error   = r_load_error;
  assign loaded_count = r_loaded_count;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes, a monitor
// pops and compares every mem_we; status outputs are checked at load boundaries.
module tb_program_loader;

  localparam int AW    = 8;
  localparam int BASE  = 0;
  localparam int DEPTH = 2**AW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clock;
  logic          reset;
  logic          load_req;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_run;
  logic          load_error;
  logic [AW:0]   loaded_count;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t         exp_q[$];
  logic [31:0] words_q[$];

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_req     (load_req),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_run      (cpu_run),
    .load_error   (load_error),
    .loaded_count (loaded_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected write.
  always @(negedge clock) begin
    if (mem_we) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  function automatic int next_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // Offer one byte after 'gap' idle cycles; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(negedge clock);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      #1 check("ready_gap", 64'(byte_ready), 64'd1);
    end
    @(negedge clock);
    byte_valid = 1'b1;
    byte_data  = b;
    #1 check("ready_offer", 64'(byte_ready), 64'd1);
    @(posedge clock);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mem_we"},    64'(mem_we), 64'd0);
    check({tag, "_mem_addr"},  64'(mem_addr), 64'(BASE));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_cpu_run"},   64'(cpu_run), 64'd0);
    check({tag, "_load_err"},  64'(load_error), 64'd0);
    check({tag, "_count"},     64'(loaded_count), 64'd0);
  endtask

  task automatic pulse_load_req();
    @(negedge clock);
    load_req   = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    #1 check("ready_with_load_req", 64'(byte_ready), 64'd0);
    @(negedge clock);
    load_req   = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("lr_cpu_run",  64'(cpu_run), 64'd0);
    check("lr_load_err", 64'(load_error), 64'd0);
    check("lr_count",    64'(loaded_count), 64'd0);
  endtask

  // Reference model: word i lands at (BASE+i) mod depth, bytes sent big-endian.
  task automatic load_stream(input int mode);
    int n;
    n = words_q.size();
    for (int i = 0; i < n; i++) begin
      wr_t e;
      e.addr = AW'((BASE + i) % DEPTH);
      e.data = words_q[i];
      exp_q.push_back(e);
    end
    send_byte(8'(n / 256), next_gap(mode));
    send_byte(8'(n % 256), next_gap(mode));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(8'(words_q[i] >> (24 - 8 * k)), next_gap(mode));
      end
    end
    @(negedge clock);
    byte_valid = 1'b0;
    #1;
    if (n > 0) begin
      check("last_we_now", 64'(mem_we), 64'd1);
      check("run_not_yet", 64'(cpu_run), 64'd0);
      @(negedge clock);
      #1;
    end
    check("run_up",      64'(cpu_run), 64'd1);
    check("we_done",     64'(mem_we), 64'd0);
    check("count_final", 64'(loaded_count), 64'(n));
    check("err_clear",   64'(load_error), 64'd0);
    check("q_drained",   64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    load_req   = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(negedge clock);
    #1;
    check_reset_vals("rst");
    check("rst_ready", 64'(byte_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // Two-word program at full rate.
    words_q = '{32'h20080005, 32'h01095020};
    load_stream(0);

    // Same program with byte_valid toggling every cycle.
    pulse_load_req();
    load_stream(1);

    // Empty program.
    pulse_load_req();
    words_q = '{};
    load_stream(0);

    // Oversized header (257 words) lands in the error state.
    pulse_load_req();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      #1;
      check("err_flag",  64'(load_error), 64'd1);
      check("err_ready", 64'(byte_ready), 64'd0);
      check("err_run",   64'(cpu_run), 64'd0);
    end
    pulse_load_req();
    words_q = '{$urandom};
    load_stream(0);

    // Abort mid-word: the two partial bytes must not reach memory.
    pulse_load_req();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    pulse_load_req();
    words_q = '{32'hDEADBEEF};
    load_stream(0);

    // Randomized programs with random gaps.
    for (int r = 0; r < 4; r++) begin
      int n;
      pulse_load_req();
      n = int'($urandom_range(1, 6));
      words_q = '{};
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      load_stream(2);
    end

    // Largest legal program: exactly depth words.
    pulse_load_req();
    words_q = '{};
    for (int i = 0; i < DEPTH; i++) words_q.push_back($urandom);
    load_stream(0);

    // Reset in the middle of DATA with a byte offered.
    pulse_load_req();
    words_q = '{$urandom};
    begin
      wr_t e;
      e.addr = AW'(BASE);
      e.data = words_q[0];
      exp_q.push_back(e);
    end
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    for (int k = 0; k < 4; k++) send_byte(8'(words_q[0] >> (24 - 8 * k)), 0);
    send_byte(8'hA5, 0);
    @(negedge clock);
    reset      = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    @(negedge clock);
    #1;
    check_reset_vals("mid_rst");
    load_req = 1'b1;
    @(negedge clock);
    #1;
    check_reset_vals("rst_lr");
    reset      = 1'b0;
    load_req   = 1'b0;
    byte_valid = 1'b0;
    #1 check("post_rst_ready", 64'(byte_ready), 64'd1);

    // Normal load after reset.
    words_q = '{$urandom, $urandom};
    load_stream(2);

    repeat (3) @(negedge clock);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
